// File: rtl/rv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RISC-V control unit.
// The ALU operation, immediate format and instruction class are decoded once per instruction and reused in every later state.
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100
  } alu_op_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10
  } imm_src_e;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BEQ,
    CLS_BNE,
    CLS_NONE
  } instr_class_e;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    TRAP
  } state_e;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    instr_class_e cls;
    alu_op_e      alu_ctrl;
    imm_src_e     imm_src;
    logic         alu_src;
    logic         legal;
  } dec_t;

endpackage

// File: rtl/rv_main_decoder.sv
// Combinational instruction decoder: maps the latched instruction word to its class and ALU/immediate controls.
// The control FSM decides when these controls are actually driven onto the datapath.
module rv_main_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output dec_t        dec
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_ir_bits;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];
  // Register numbers and immediates are consumed by the datapath, not the controller.
  assign unused_ir_bits = ^{ir[24:15], ir[11:7]};

  always_comb begin
    dec.cls      = CLS_NONE;
    dec.alu_ctrl = ALU_ADD;
    dec.imm_src  = IMM_I;
    dec.alu_src  = 1'b0;
    dec.legal    = 1'b0;
    unique case (opcode)
      OPC_R: begin
        dec.cls   = CLS_ALU;
        dec.legal = 1'b1;
        case ({funct7, funct3})
          {7'h00, 3'b000}: dec.alu_ctrl = ALU_ADD;
          {7'h20, 3'b000}: dec.alu_ctrl = ALU_SUB;
          {7'h00, 3'b100}: dec.alu_ctrl = ALU_XOR;
          {7'h00, 3'b110}: dec.alu_ctrl = ALU_OR;
          {7'h00, 3'b111}: dec.alu_ctrl = ALU_AND;
          default:         dec.legal    = 1'b0;
        endcase
      end
      OPC_I: begin
        dec.cls     = CLS_ALU;
        dec.alu_src = 1'b1;
        dec.legal   = 1'b1;
        case (funct3)
          3'b000:  dec.alu_ctrl = ALU_ADD;
          3'b100:  dec.alu_ctrl = ALU_XOR;
          3'b110:  dec.alu_ctrl = ALU_OR;
          3'b111:  dec.alu_ctrl = ALU_AND;
          default: dec.legal    = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        dec.cls     = CLS_LOAD;
        dec.alu_src = 1'b1;
        dec.legal   = (funct3 == 3'b010);
      end
      OPC_STORE: begin
        dec.cls     = CLS_STORE;
        dec.alu_src = 1'b1;
        dec.imm_src = IMM_S;
        dec.legal   = (funct3 == 3'b010);
      end
      OPC_BRANCH: begin
        dec.alu_ctrl = ALU_SUB;
        dec.imm_src  = IMM_B;
        dec.cls      = (funct3 == 3'b001) ? CLS_BNE : CLS_BEQ;
        dec.legal    = (funct3 == 3'b000) || (funct3 == 3'b001);
      end
      default: ;
    endcase
    if (!dec.legal) dec.cls = CLS_NONE;
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle control FSM: fetch handshake, decode, execute, memory and writeback sequencing.
// Outputs are decoded from the current state and latched instruction; branch and store-retire strobes also look at EQ / mem_ack.
module mc_control_unit
  import rv_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  EQ,
  input  logic                  mem_ack,
  output logic [2:0]            ALUctrl,
  output logic                  ALUsrc,
  output logic [1:0]            ImmSrc,
  output logic                  ResultSrc,
  output logic                  RegWrite,
  output logic                  mem_req,
  output logic                  MemWrite,
  output logic                  PCsrc,
  output logic                  pc_en,
  output logic                  illegal,
  output state_e                dbg_state
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  dec_t                  dec;

  rv_main_decoder u_dec (
    .ir  (ir_q[31:0]),
    .dec (dec)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    unique case (state_q)
      FETCH: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = DECODE;
        end
      end
      DECODE: state_d = dec.legal ? EXEC : TRAP;
      EXEC: begin
        case (dec.cls)
          CLS_ALU:              state_d = WB;
          CLS_LOAD, CLS_STORE:  state_d = MEM;
          CLS_BEQ, CLS_BNE:     state_d = FETCH;
          default:              state_d = TRAP;
        endcase
      end
      MEM: begin
        if (mem_ack) state_d = (dec.cls == CLS_STORE) ? FETCH : WB;
      end
      WB:      state_d = FETCH;
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    instr_ready = (state_q == FETCH);
    illegal     = (state_q == TRAP);
    ALUctrl     = ALU_ADD;
    ALUsrc      = 1'b0;
    ImmSrc      = IMM_I;
    ResultSrc   = 1'b0;
    RegWrite    = 1'b0;
    mem_req     = 1'b0;
    MemWrite    = 1'b0;
    PCsrc       = 1'b0;
    pc_en       = 1'b0;
    // ALU/immediate controls stay stable for the whole EXEC..MEM/WB span of an instruction.
    if (state_q == EXEC || state_q == MEM || state_q == WB) begin
      ALUctrl = dec.alu_ctrl;
      ALUsrc  = dec.alu_src;
      ImmSrc  = dec.imm_src;
    end
    case (state_q)
      EXEC: begin
        if (dec.cls == CLS_BEQ || dec.cls == CLS_BNE) begin
          pc_en = 1'b1;
          PCsrc = (dec.cls == CLS_BEQ) ? EQ : !EQ;
        end
      end
      MEM: begin
        mem_req  = 1'b1;
        MemWrite = (dec.cls == CLS_STORE);
        pc_en    = (dec.cls == CLS_STORE) && mem_ack;
      end
      WB: begin
        RegWrite  = 1'b1;
        ResultSrc = (dec.cls == CLS_LOAD);
        pc_en     = 1'b1;
      end
      default: ;
    endcase
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: walks each instruction class cycle by cycle against hand-computed output vectors.
module tb_mc_control_unit;
  import rv_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        EQ;
  logic        mem_ack;
  logic [2:0]  ALUctrl;
  logic        ALUsrc;
  logic [1:0]  ImmSrc;
  logic        ResultSrc;
  logic        RegWrite;
  logic        mem_req;
  logic        MemWrite;
  logic        PCsrc;
  logic        pc_en;
  logic        illegal;
  state_e      dbg_state;

  int checks = 0;
  int errors = 0;
  int pc_cnt = 0;

  mc_control_unit #(.DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .EQ          (EQ),
    .mem_ack     (mem_ack),
    .ALUctrl     (ALUctrl),
    .ALUsrc      (ALUsrc),
    .ImmSrc      (ImmSrc),
    .ResultSrc   (ResultSrc),
    .RegWrite    (RegWrite),
    .mem_req     (mem_req),
    .MemWrite    (MemWrite),
    .PCsrc       (PCsrc),
    .pc_en       (pc_en),
    .illegal     (illegal),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (rst_n === 1'b1 && pc_en === 1'b1) pc_cnt <= pc_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  // Order: ready, ALUctrl[3], ALUsrc, ImmSrc[2], ResultSrc, RegWrite, mem_req, MemWrite, PCsrc, pc_en, illegal
  function automatic logic [13:0] e(input logic rdy, input logic [2:0] alu, input logic src,
                                    input logic [1:0] imm, input logic res, input logic rw,
                                    input logic mreq, input logic mw, input logic pcs,
                                    input logic pce, input logic ill);
    return {rdy, alu, src, imm, res, rw, mreq, mw, pcs, pce, ill};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [13:0] exp);
    logic [13:0] obs;
    #1;
    obs = {instr_ready, ALUctrl, ALUsrc, ImmSrc, ResultSrc, RegWrite, mem_req, MemWrite,
           PCsrc, pc_en, illegal};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input state_e exp);
    checks++;
    assert (dbg_state === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, dbg_state, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  logic [13:0] o_fetch, o_zero, o_trap;

  // directed steps
  initial begin
    o_fetch = e(1'b1, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    o_zero  = e(1'b0, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    o_trap  = e(1'b0, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; EQ = 1'b0; mem_ack = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk("reset_outputs", o_fetch);
    chk_state("reset_state", FETCH);

    // add x3,x1,x2 with valid held
    instr = 32'h002081B3; instr_valid = 1'b1;
    tick(); chk("add_decode", o_zero);
    tick(); chk("add_exec", e(1'b0, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick(); chk("add_wb", e(1'b0, 3'b000, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    tick(); chk("add_back_fetch", o_fetch);

    // sub then xori, valid still held
    instr = 32'h402081B3;
    tick(); chk("sub_decode", o_zero);
    tick(); chk("sub_exec", e(1'b0, 3'b001, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick(); chk("sub_wb", e(1'b0, 3'b001, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    tick(); chk("sub_fetch", o_fetch);
    instr = 32'h0050C093;
    tick(); chk("xori_decode", o_zero);
    tick(); chk("xori_exec", e(1'b0, 3'b100, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick(); chk("xori_wb", e(1'b0, 3'b100, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    tick(); chk("xori_fetch", o_fetch);
    chk_int("pc_en_after_alu", pc_cnt, 3);

    // beq taken, then bne with EQ=1 (not taken) and EQ=0 (taken)
    instr = 32'h00208063; EQ = 1'b1;
    tick(); chk("beq_decode", o_zero);
    tick(); chk("beq_exec", e(1'b0, 3'b001, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    instr = 32'h00209063;
    tick(); chk("beq_fetch", o_fetch);
    tick(); chk("bne_decode", o_zero);
    tick(); chk("bne_exec_eq1", e(1'b0, 3'b001, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    EQ = 1'b0;
    chk("bne_exec_eq0", e(1'b0, 3'b001, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    instr = 32'h0000A283;
    tick(); chk("bne_fetch", o_fetch);
    chk_int("pc_en_after_branch", pc_cnt, 5);

    // lw with mem_ack on the third MEM cycle
    tick(); chk("lw_decode", o_zero);
    tick(); chk("lw_exec", e(1'b0, 3'b000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick(); chk("lw_mem1", e(1'b0, 3'b000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tick(); chk("lw_mem2", e(1'b0, 3'b000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tick(); mem_ack = 1'b1;
    chk("lw_mem3_ack", e(1'b0, 3'b000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tick(); mem_ack = 1'b0;
    chk("lw_wb", e(1'b0, 3'b000, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    instr_valid = 1'b0;
    tick(); chk("lw_fetch", o_fetch);
    tick(); chk("fetch_stall_no_valid", o_fetch);
    chk_state("stall_state", FETCH);

    // illegal all-zero word traps until reset
    instr = 32'h00000000; instr_valid = 1'b1;
    tick(); chk("ill_decode", o_zero);
    tick(); chk("ill_trap", o_trap);
    tick(); tick(); chk("ill_trap_sticky", o_trap);
    chk_state("trap_state", TRAP);
    rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    chk("trap_cleared", o_fetch);
    chk_int("pc_en_after_trap", pc_cnt, 6);

    // sw aborted by reset during the memory wait
    instr = 32'h0020A223;
    tick(); chk("sw_decode", o_zero);
    tick(); chk("sw_exec", e(1'b0, 3'b000, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick(); chk("sw_mem1", e(1'b0, 3'b000, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    tick(); chk("sw_mem2", e(1'b0, 3'b000, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    chk("sw_abort", o_fetch);
    chk_int("pc_en_after_abort", pc_cnt, 6);

    // the same sw afterwards completes with an immediate ack
    tick(); chk("sw2_decode", o_zero);
    tick(); chk("sw2_exec", e(1'b0, 3'b000, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick(); mem_ack = 1'b1;
    chk("sw2_mem_ack", e(1'b0, 3'b000, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
    instr_valid = 1'b0;
    tick(); mem_ack = 1'b0;
    chk("sw2_fetch", o_fetch);
    tick();
    chk_int("pc_en_total", pc_cnt, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
